// File: rtl/line_tap_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : line_tap_packetizer
//  Brief    : Timestamps masked line changes into a record FIFO and batches
//             the records into bulk IN packets on the usb2_top buf_in port.
//  Revision : 1.0  initial release
// ============================================================================
module line_tap_packetizer #(
    parameter int NUM_LINES    = 32,
    parameter int TS_WIDTH     = 32,
    parameter int FIFO_DEPTH   = 256,
    parameter int MAX_EVENTS   = 56,
    parameter int FLUSH_CYCLES = 50000
) (
    input  logic                          ext_clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUM_LINES-1:0]          line_mask,
    input  logic [NUM_LINES-1:0]          lines_in,
    input  logic                          usb_configured,
    input  logic                          buf_in_ready,
    input  logic                          buf_in_commit_ack,
    output logic [8:0]                    buf_in_addr,
    output logic [7:0]                    buf_in_data,
    output logic                          buf_in_wren,
    output logic                          buf_in_commit,
    output logic [9:0]                    buf_in_commit_len,
    output logic [$clog2(FIFO_DEPTH):0]   stat_used,
    output logic                          stat_full,
    output logic                          stat_empty,
    output logic [15:0]                   stat_drop_count
);

    localparam int c_REC_BYTES = 1 + TS_WIDTH/8 + NUM_LINES/8;
    localparam int c_REC_W     = 8 * c_REC_BYTES;
    localparam int c_AW        = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W     = $clog2(MAX_EVENTS + 1);
    localparam int c_TMR_W     = $clog2(FLUSH_CYCLES + 1);
    localparam int c_BYTE_W    = $clog2(c_REC_BYTES);

    localparam logic [c_AW:0]       c_DEPTH     = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_MAX_EV    = c_CNT_W'(MAX_EVENTS);
    localparam logic [c_TMR_W-1:0]  c_FLUSH     = c_TMR_W'(FLUSH_CYCLES);
    localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(c_REC_BYTES - 1);
    localparam logic [9:0]          c_REC_LEN   = 10'(c_REC_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_LAT     = 3'd2,
        ST_WR      = 3'd3,
        ST_GATHER  = 3'd4,
        ST_COMMIT  = 3'd5,
        ST_ACKWAIT = 3'd6
    } state_t;

    logic [NUM_LINES-1:0] r_s1, r_s2, r_s3;
    logic [1:0]           r_vld;
    logic                 r_snap_done;
    logic [TS_WIDTH-1:0]  r_ts;
    logic                 r_ovf_pend, r_wrap_pend;
    logic [15:0]          r_drop;

    logic [c_REC_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wptr, r_rptr;
    logic [c_AW:0]        r_used;
    logic [c_REC_W-1:0]   r_rdata;

    state_t               r_state, w_state_nxt;
    logic [8:0]           r_addr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BYTE_W-1:0]  r_byte;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_REC_W-1:0]   r_sh;

    logic                 w_s3_valid, w_snap, w_change, w_wr_req, w_wr_ok, w_drop;
    logic                 w_rd, w_full, w_empty, w_last_byte, w_start;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic [c_REC_W-1:0]   w_rec;

    assign w_s3_valid = (r_vld == 2'd3);
    assign w_snap     = w_s3_valid & ~r_snap_done;
    assign w_change   = w_s3_valid & r_snap_done & enable & (|((r_s2 ^ r_s3) & line_mask));
    assign w_wr_req   = w_snap | w_change;
    assign w_rd       = (r_state == ST_RD);
    assign w_full     = (r_used == c_DEPTH);
    assign w_empty    = (r_used == '0);
    // A read in the same cycle frees a slot, so a write at full still lands.
    assign w_wr_ok    = w_wr_req & (~w_full | w_rd);
    assign w_drop     = w_wr_req & ~w_wr_ok;
    assign w_rec      = {r_ovf_pend, r_wrap_pend, w_snap, 5'b0, r_ts, r_s2};

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_vld       <= 2'd0;
            r_snap_done <= 1'b0;
            r_ts        <= '0;
            r_ovf_pend  <= 1'b0;
            r_wrap_pend <= 1'b0;
            r_drop      <= 16'd0;
        end else begin
            r_s1 <= lines_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_vld != 2'd3)
                r_vld <= r_vld + 2'd1;
            if (w_snap)
                r_snap_done <= 1'b1;
            r_ts <= r_ts + TS_WIDTH'(1);
            if (w_wr_ok)
                r_ovf_pend <= 1'b0;
            else if (w_drop)
                r_ovf_pend <= 1'b1;
            // A wrap on the same edge as a write belongs to the next record.
            r_wrap_pend <= (w_wr_ok ? 1'b0 : r_wrap_pend) | (&r_ts);
            if (w_drop && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    always_ff @(posedge ext_clk) begin
        if (w_wr_ok)
            r_mem[r_wptr] <= w_rec;
    end

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_used  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_wr_ok)
                r_wptr <= r_wptr + c_AW'(1);
            if (w_rd) begin
                r_rptr  <= r_rptr + c_AW'(1);
                r_rdata <= r_mem[r_rptr];
            end
            case ({w_wr_ok, w_rd})
                2'b10:   r_used <= r_used + (c_AW+1)'(1);
                2'b01:   r_used <= r_used - (c_AW+1)'(1);
                default: r_used <= r_used;
            endcase
        end
    end

    assign w_last_byte = (r_byte == c_LAST_BYTE);
    assign w_cnt_inc   = r_cnt + c_CNT_W'(1);
    assign w_start     = (r_state == ST_IDLE) && (w_state_nxt == ST_RD);

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (usb_configured && buf_in_ready && !w_empty) w_state_nxt = ST_RD;
            ST_RD:      w_state_nxt = ST_LAT;
            ST_LAT:     w_state_nxt = ST_WR;
            ST_WR: begin
                if (w_last_byte) begin
                    if (w_cnt_inc == c_MAX_EV)
                        w_state_nxt = ST_COMMIT;
                    else if (!w_empty)
                        w_state_nxt = ST_RD;
                    else
                        w_state_nxt = ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (!w_empty)
                    w_state_nxt = ST_RD;
                else if (r_timer >= c_FLUSH)
                    w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT:  if (buf_in_commit_ack) w_state_nxt = ST_ACKWAIT;
            ST_ACKWAIT: if (!buf_in_commit_ack) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= 9'd0;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_timer <= '0;
            r_sh    <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= 9'd0;
                r_cnt   <= '0;
                r_timer <= '0;
            end else if (r_timer != c_FLUSH) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
            if (r_state == ST_LAT) begin
                r_sh   <= r_rdata;
                r_byte <= '0;
            end
            // Record is shifted out MSB byte first.
            if (r_state == ST_WR) begin
                r_sh   <= r_sh << 8;
                r_addr <= r_addr + 9'd1;
                r_byte <= r_byte + c_BYTE_W'(1);
                if (w_last_byte)
                    r_cnt <= w_cnt_inc;
            end
        end
    end

    assign buf_in_wren       = (r_state == ST_WR);
    assign buf_in_addr       = buf_in_wren ? r_addr : 9'd0;
    assign buf_in_data       = buf_in_wren ? r_sh[c_REC_W-1 -: 8] : 8'd0;
    assign buf_in_commit     = (r_state == ST_COMMIT);
    assign buf_in_commit_len = buf_in_commit ? (10'(r_cnt) * c_REC_LEN) : 10'd0;
    assign stat_used         = r_used;
    assign stat_full         = w_full;
    assign stat_empty        = w_empty;
    assign stat_drop_count   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_line_tap_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_tap_packetizer
//  Brief    : Randomised scoreboard bench for line_tap_packetizer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_tap_packetizer;

    localparam int NL    = 32;
    localparam int TSW   = 16;
    localparam int DEPTH = 256;
    localparam int MAXEV = 56;
    localparam int FLUSH = 200;
    localparam int RB    = 1 + TSW/8 + NL/8;
    localparam int RW    = 8 * RB;

    logic          ext_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [NL-1:0] line_mask = '1;
    logic [NL-1:0] lines_in;
    logic          usb_configured = 1'b1;
    logic          buf_in_ready = 1'b1;
    logic          buf_in_commit_ack = 1'b0;
    logic [8:0]    buf_in_addr;
    logic [7:0]    buf_in_data;
    logic          buf_in_wren;
    logic          buf_in_commit;
    logic [9:0]    buf_in_commit_len;
    logic [8:0]    stat_used;
    logic          stat_full;
    logic          stat_empty;
    logic [15:0]   stat_drop_count;

    line_tap_packetizer #(
        .NUM_LINES(NL), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH),
        .MAX_EVENTS(MAXEV), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .ext_clk(ext_clk), .reset_n(reset_n), .enable(enable),
        .line_mask(line_mask), .lines_in(lines_in),
        .usb_configured(usb_configured), .buf_in_ready(buf_in_ready),
        .buf_in_commit_ack(buf_in_commit_ack), .buf_in_addr(buf_in_addr),
        .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
        .stat_used(stat_used), .stat_full(stat_full), .stat_empty(stat_empty),
        .stat_drop_count(stat_drop_count)
    );

    always #5 ext_clk = ~ext_clk;

    int tb_cyc;
    always @(posedge ext_clk or negedge reset_n)
        if (!reset_n) tb_cyc <= 0;
        else          tb_cyc <= tb_cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference model: record queue plus pending flags, in absolute cycle time.
    logic [RW-1:0] sb[$];
    int            lens[$];
    logic [NL-1:0] cur_lines;
    int            last_det = 0;
    bit            ovf_pend = 0;
    int            model_drops = 0;
    bit            fill_phase = 0;
    int            occ = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_write(input int det, input logic [NL-1:0] v, input bit snap);
        logic [7:0] fl;
        if (fill_phase && occ >= DEPTH) begin
            ovf_pend = 1;
            if (model_drops < 65535) model_drops++;
        end else begin
            fl = {ovf_pend, ((det >> TSW) != (last_det >> TSW)), snap, 5'b0};
            sb.push_back({fl, det[TSW-1:0], v});
            ovf_pend = 0;
            last_det = det;
            if (fill_phase) occ++;
        end
    endfunction

    // Called at a negedge; the change is seen by the tap two edges later.
    task automatic drive(input logic [NL-1:0] v);
        if (enable && (((v ^ cur_lines) & line_mask) != '0))
            model_write(tb_cyc + 2, v, 1'b0);
        cur_lines = v;
        lines_in  = v;
    endtask

    int            pkt_bytes = 0;
    int            nb = 0;
    bit            commit_seen = 0;
    logic [RW-1:0] acc;
    logic [RW-1:0] exp_rec;

    always @(negedge ext_clk) begin
        if (!reset_n) begin
            pkt_bytes   = 0;
            nb          = 0;
            commit_seen = 0;
        end else begin
            if (buf_in_wren) begin
                check("byte_addr", 64'(buf_in_addr), 64'(pkt_bytes));
                pkt_bytes++;
                acc = {acc[RW-9:0], buf_in_data};
                nb++;
                if (nb == RB) begin
                    nb = 0;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL record: got unexpected %0h expected none", acc);
                    end else begin
                        exp_rec = sb.pop_front();
                        check("record", 64'(acc), 64'(exp_rec));
                    end
                end
            end
            if (buf_in_commit && !commit_seen) begin
                commit_seen = 1;
                check("commit_len", 64'(buf_in_commit_len), 64'(pkt_bytes));
                lens.push_back(int'(buf_in_commit_len));
                pkt_bytes = 0;
            end
            if (!buf_in_commit) commit_seen = 0;
        end
    end

    initial forever begin
        @(negedge ext_clk);
        if (!reset_n)                                   buf_in_commit_ack = 1'b0;
        else if (buf_in_commit && !buf_in_commit_ack)   buf_in_commit_ack = 1'b1;
        else if (!buf_in_commit && buf_in_commit_ack)   buf_in_commit_ack = 1'b0;
    end

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 20000) begin
            @(negedge ext_clk);
            n++;
            if (sb.size() == 0 && pkt_bytes == 0 && nb == 0 && !buf_in_commit &&
                !buf_in_commit_ack && stat_empty)
                quiet++;
            else
                quiet = 0;
        end
        checks++;
        if (quiet < 4) begin
            failures++;
            $display("FAIL %s: got %0d records outstanding expected 0", name, sb.size());
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_addr"},   64'(buf_in_addr), 64'd0);
        check({tag, "_data"},   64'(buf_in_data), 64'd0);
        check({tag, "_wren"},   64'(buf_in_wren), 64'd0);
        check({tag, "_commit"}, 64'(buf_in_commit), 64'd0);
        check({tag, "_len"},    64'(buf_in_commit_len), 64'd0);
        check({tag, "_used"},   64'(stat_used), 64'd0);
        check({tag, "_full"},   64'(stat_full), 64'd0);
        check({tag, "_empty"},  64'(stat_empty), 64'd1);
        check({tag, "_drops"},  64'(stat_drop_count), 64'd0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        lines_in  = 32'hA5A5_0001;
        cur_lines = lines_in;
        repeat (3) @(negedge ext_clk);
        check_outputs_reset("rst");
        reset_n = 1'b1;
        model_write(3, cur_lines, 1'b1);

        // Snapshot only; changes with enable low are ignored.
        repeat (10) @(negedge ext_clk);
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge ext_clk);
            drive(cur_lines ^ 32'h0000_00F0);
        end
        wait_idle("snapshot");
        check("snap_pkts", 64'(lens.size()), 64'd1);
        if (lens.size() > 0) check("snap_len", 64'(lens[0]), 64'(RB));
        lens.delete();

        // Three toggles of bit 0, ten cycles apart.
        enable = 1'b1;
        repeat (4) @(negedge ext_clk);
        for (int i = 0; i < 3; i++) begin
            drive(cur_lines ^ 32'h1);
            repeat (9) @(negedge ext_clk);
            @(negedge ext_clk);
        end
        wait_idle("toggle3");
        check("toggle_pkts", 64'(lens.size()), 64'd1);
        if (lens.size() > 0) check("toggle_len", 64'(lens[0]), 64'(3 * RB));
        lens.delete();

        // 60 back-to-back changes: one full packet then a 4-record flush.
        for (int i = 0; i < 60; i++) begin
            @(negedge ext_clk);
            drive(cur_lines ^ ($urandom() | 32'h1));
        end
        wait_idle("burst");
        check("burst_pkts", 64'(lens.size()), 64'd2);
        if (lens.size() == 2) begin
            check("burst_len0", 64'(lens[0]), 64'(MAXEV * RB));
            check("burst_len1", 64'(lens[1]), 64'(4 * RB));
        end
        lens.delete();

        // Random values, random masks, one group with capture disabled.
        for (int g = 0; g < 4; g++) begin
            enable    = (g != 2);
            line_mask = $urandom();
            repeat (4) @(negedge ext_clk);
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 12)) @(negedge ext_clk);
                @(negedge ext_clk);
                drive($urandom());
            end
            repeat (4) @(negedge ext_clk);
        end
        enable    = 1'b1;
        line_mask = '1;
        wait_idle("random");

        // Unconfigured: records accumulate, no packet starts.
        usb_configured = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (3) @(negedge ext_clk);
            drive(cur_lines ^ ($urandom() | 32'h1));
        end
        repeat (20) @(negedge ext_clk);
        check("unconf_used", 64'(stat_used), 64'd5);
        check("unconf_wren", 64'(buf_in_wren), 64'd0);
        usb_configured = 1'b1;
        wait_idle("unconfigured");

        // Overflow with the IN buffer busy.
        buf_in_ready = 1'b0;
        fill_phase   = 1;
        occ          = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge ext_clk);
            drive(cur_lines ^ ($urandom() | 32'h1));
        end
        repeat (6) @(negedge ext_clk);
        check("ovf_full",  64'(stat_full), 64'd1);
        check("ovf_used",  64'(stat_used), 64'(DEPTH));
        check("ovf_empty", 64'(stat_empty), 64'd0);
        check("ovf_drops", 64'(stat_drop_count), 64'(model_drops));
        fill_phase   = 0;
        buf_in_ready = 1'b1;
        wait_idle("drain");
        drive(cur_lines ^ 32'h8000_0000);
        wait_idle("post_ovf");

        // Timestamp wrap: one record before, two after.
        while (tb_cyc < 65528) @(negedge ext_clk);
        drive(cur_lines ^ 32'h2);
        while (tb_cyc < 65540) @(negedge ext_clk);
        drive(cur_lines ^ 32'h4);
        while (tb_cyc < 65550) @(negedge ext_clk);
        drive(cur_lines ^ 32'h8);
        wait_idle("wrap");

        // Asynchronous reset in the middle of a record.
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge ext_clk);
            drive(cur_lines ^ ($urandom() | 32'h1));
        end
        found = 0;
        for (int n = 0; n < 200 && found == 0; n++) begin
            @(negedge ext_clk);
            if (buf_in_wren && buf_in_addr == 9'd2) found = 1;
        end
        check("reach_wr", 64'(found), 64'd1);
        @(posedge ext_clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        ovf_pend    = 0;
        last_det    = 0;
        model_drops = 0;
        #1;
        check_outputs_reset("arst");
        repeat (3) @(negedge ext_clk);
        reset_n = 1'b1;
        model_write(3, cur_lines, 1'b1);
        wait_idle("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
